icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache that answers the datapath's instruction fetch requests.
- Datapath side: imemREN, imemaddr, imemload, ihit, halt.
- Memory side: the block issues single-word fills to the memory controller (iREN, iaddr, iwait, iload).
- Sits between the pipeline's fetch stage and the memory controller. It also keeps hit and miss counters for performance checks.

Parameters:
- NFRAMES, 16, number of one-word frames; must be a power of 2.
- IDX_W, 4, index width, equal to log2(NFRAMES).
- CNT_W, 16, width of the hit and miss counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- halt  in  1  datapath halted; suppresses new hits and new misses.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  requested instruction byte address.
- ihit  out  1  requested word is valid on imemload this cycle.
- imemload  out  32  instruction word returned to the datapath.
- iwait  in  1  memory controller busy; fill data is not yet valid.
- iload  in  32  fill data from the memory controller.
- iREN  out  1  fill request to the memory controller.
- iaddr  out  32  fill word address (bits [1:0] forced to 0).
- hit_cnt  out  CNT_W  number of hit cycles, saturating.
- miss_cnt  out  CNT_W  number of misses started, saturating.

Behaviour:
- Address split:
  - [1:0] byte offset, ignored.
  - [IDX_W+1:2] index.
  - [31:IDX_W+2] tag, 26 bits at the defaults.
- Storage per frame: valid bit, tag, 32-bit data word. No writes from the datapath; the block does no coherence.
- Reset (asynchronous) drives all of the following:
  - every valid bit cleared; state goes to IDLE;
  - hit_cnt and miss_cnt set to 0;
  - iREN falls immediately, even mid-fill;
  - while reset is held: ihit=0, iREN=0, iaddr=0, imemload=0.
- FSM has two states, IDLE and FETCH.
- IDLE:
  - hit = imemREN & !halt & valid[idx] & tag match. Combinational: ihit=1 and imemload=data[idx] in the same cycle (0-cycle hit latency).
  - imemload = data[idx] whenever the frame is valid; otherwise 0.
  - On imemREN & !halt & !hit: latch {tag,idx} into the miss register and go to FETCH next edge. miss_cnt increments once.
  - iREN=0 in IDLE.
- FETCH:
  - iREN=1; iaddr = {latched tag, latched idx, 2'b00}; ihit=0.
  - While iwait=1: hold state and outputs.
  - At the first edge with iwait=0: write iload, tag and valid=1 into the latched frame (overwriting any previous occupant), then go to IDLE.
- Miss timing: request in cycle 0 (IDLE); FETCH from cycle 1; with iwait=0 in cycle 1, fill at the end of cycle 1 and ihit=1 in cycle 2. Each extra iwait cycle adds one cycle.
- imemaddr changes or imemREN drops during FETCH: the fill is not aborted. It completes with the latched address; the new address is evaluated in IDLE afterwards.
- halt:
  - Forces ihit=0 and blocks new misses in IDLE.
  - A fill already in FETCH completes.
  - Cache contents are retained.
- Counters:
  - hit_cnt increments on every cycle with ihit=1.
  - miss_cnt increments on each IDLE->FETCH transition.
  - Both saturate at all-ones and never wrap.
- Simultaneous events: there is never more than one outstanding fill, and no hit is reported in a cycle where iREN=1.

Test Plan:
- Cold miss: reset, imemREN=1, imemaddr=0x00000004, iwait=0, iload=0x8C220000 -> iREN=1 and iaddr=0x00000004 in cycle 1; ihit=1 and imemload=0x8C220000 in cycle 2; miss_cnt=1.
- Hit after fill: hold 0x00000004 for 5 cycles -> ihit=1 every cycle, iREN=0, hit_cnt=5.
- Conflict: fill 0x00000000, then 0x00000040 (same index 0, different tag), then 0x00000000 -> three misses (miss_cnt=3) and correct data each time.
- Memory stall: miss on 0x00000100 with iwait=1 for 6 cycles -> iREN=1 and iaddr stable for 6 cycles; fill on the 7th cycle; ihit in the 8th.
- Address change mid-fill: miss on 0x00000200, switch to 0x00000204 during iwait=1 -> 0x200 frame is filled first; then a new miss for 0x204.
- Halt and reset: halt=1 on a cached address -> ihit=0 and no iREN. nRST low mid-FETCH -> iREN=0 immediately; after release, a previously cached address misses again.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are answered combinationally in IDLE; a miss parks the block in FETCH
// until the memory controller drops iwait, then the frame is refilled.
//
// state | meaning
// IDLE  | look up the request; answer hits, start a fill on a miss
// FETCH | single-word fill outstanding, waiting for iwait to drop
module icache_responder #(
  parameter int NFRAMES = 16,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             halt,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NFRAMES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [NFRAMES];
  logic [31:0]        data_q [NFRAMES];
  logic [TAG_W-1:0]   miss_tag_q;
  logic [IDX_W-1:0]   miss_idx_q;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               frame_valid;
  logic               lookup_hit;
  logic               start_miss;
  logic               fill;

  // Byte offset is irrelevant for word fetches.
  logic unused_offset;
  assign unused_offset = ^imemaddr[1:0];

  assign req_idx     = imemaddr[IDX_W+1:2];
  assign req_tag     = imemaddr[31:IDX_W+2];
  assign frame_valid = valid_q[req_idx];
  assign lookup_hit  = frame_valid && (tag_q[req_idx] == req_tag);
  assign imemload    = frame_valid ? data_q[req_idx] : 32'h0;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

  // Next-state and handshake outputs; hits are only ever reported from IDLE.
  always_comb begin
    state_d    = state_q;
    ihit       = 1'b0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    start_miss = 1'b0;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !halt) begin
          if (lookup_hit) begin
            ihit = 1'b1;
          end else begin
            start_miss = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_tag_q, miss_idx_q, 2'b00};
        if (!iwait) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame storage; a fill overwrites whatever occupied the latched frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < NFRAMES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill) begin
      valid_q[miss_idx_q] <= 1'b1;
      tag_q[miss_idx_q]   <= miss_tag_q;
      data_q[miss_idx_q]  <= iload;
    end
  end

  // Miss address is captured once so the fill ignores later address changes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else if (start_miss) begin
      miss_tag_q <= req_tag;
      miss_idx_q <= req_idx;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ihit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (start_miss && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios with fixed expectations plus
// a randomized run compared against an address-level cache model.
module tb_icache_responder;

  localparam int NF  = 16;
  localparam int IW  = 4;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          halt = 1'b0;
  logic          imemREN = 1'b0;
  logic          iwait = 1'b0;
  logic [31:0]   imemaddr = 32'h0;
  logic [31:0]   iload = 32'h0;
  logic          ihit, iREN;
  logic [31:0]   imemload, iaddr;
  logic [CW-1:0] hit_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;

  // Model: frame chosen by word address modulo NF; a frame remembers which
  // word address it holds. At most one pending fill.
  bit          m_valid [NF];
  logic [31:0] m_word  [NF];
  logic [31:0] m_data  [NF];
  bit          m_busy;
  logic [31:0] m_pend;
  int          m_hits, m_misses;
  logic        e_hit, e_ren;
  logic [31:0] e_load, e_addr;

  icache_responder #(.NFRAMES(NF), .IDX_W(IW), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .imemREN(imemREN),
    .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .iwait(iwait), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    for (int i = 0; i < NF; i++) begin
      m_valid[i] = 0;
      m_word[i]  = 32'h0;
      m_data[i]  = 32'h0;
    end
    m_busy = 0;
    m_pend = 32'h0;
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic void model_eval();
    int unsigned idx;
    idx    = (imemaddr >> 2) % NF;
    e_load = m_valid[idx] ? m_data[idx] : 32'h0;
    e_ren  = m_busy;
    e_addr = m_busy ? (m_pend & 32'hFFFF_FFFC) : 32'h0;
    e_hit  = !m_busy && imemREN && !halt && m_valid[idx] &&
             (m_word[idx] == (imemaddr >> 2));
  endfunction

  // What the upcoming rising edge does, given the inputs now applied.
  function automatic void model_edge();
    int unsigned idx;
    model_eval();
    if (m_busy) begin
      if (!iwait) begin
        idx = (m_pend >> 2) % NF;
        m_valid[idx] = 1;
        m_word[idx]  = m_pend >> 2;
        m_data[idx]  = iload;
        m_busy = 0;
      end
    end else if (imemREN && !halt) begin
      if (e_hit) begin
        if (m_hits < SAT) m_hits++;
      end else begin
        m_busy = 1;
        m_pend = imemaddr;
        if (m_misses < SAT) m_misses++;
      end
    end
  endfunction

  task automatic cyc(input logic ren, input logic [31:0] a, input logic h,
                     input logic w, input logic [31:0] ld);
    @(negedge CLK);
    imemREN = ren; imemaddr = a; halt = h; iwait = w; iload = ld;
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; imemREN = 1'b0; halt = 1'b0; iwait = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h4;
    #1;
    model_reset();
    checks++;
    if ({ihit, iREN, iaddr, imemload, hit_cnt, miss_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_hold ihit=%b iREN=%b iaddr=%h imemload=%h hit=%0d miss=%0d (want all 0)",
               ihit, iREN, iaddr, imemload, hit_cnt, miss_cnt);
    end
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_cold_miss();
    cyc(1, 32'h4, 0, 0, 32'h8C22_0000);
    checks++;
    if (iREN !== 1'b0 || ihit !== 1'b0) begin
      failures++;
      $display("FAIL cold_c0 iREN=%b ihit=%b (want 0 0)", iREN, ihit);
    end
    model_edge();
    cyc(1, 32'h4, 0, 0, 32'h8C22_0000);
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h4 || ihit !== 1'b0) begin
      failures++;
      $display("FAIL cold_c1 iREN=%b iaddr=%h ihit=%b (want 1 00000004 0)", iREN, iaddr, ihit);
    end
    model_edge();
  endtask

  task automatic test_hit_after_fill();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h4, 0, 0, $urandom);
      checks++;
      if (ihit !== 1'b1 || imemload !== 32'h8C22_0000 || iREN !== 1'b0) begin
        failures++;
        $display("FAIL hit_fill_%0d ihit=%b imemload=%h iREN=%b (want 1 8c220000 0)",
                 i, ihit, imemload, iREN);
      end
      model_edge();
    end
    cyc(0, 32'h4, 0, 0, 32'h0);
    checks++;
    if (hit_cnt !== CW'(5) || miss_cnt !== CW'(1)) begin
      failures++;
      $display("FAIL hit_fill_cnt hit=%0d miss=%0d (want 5 1)", hit_cnt, miss_cnt);
    end
    model_edge();
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [3];
    logic [31:0] vals  [3];
    addrs[0] = 32'h0;  addrs[1] = 32'h40; addrs[2] = 32'h0;
    vals[0] = 32'h1111_0000; vals[1] = 32'h2222_0040; vals[2] = 32'h3333_0000;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1, addrs[k], 0, 0, vals[k]);
      checks++;
      if (ihit !== 1'b0) begin
        failures++;
        $display("FAIL conflict_miss_%0d ihit=%b (want 0)", k, ihit);
      end
      model_edge();
      cyc(1, addrs[k], 0, 0, vals[k]);
      model_edge();
      cyc(1, addrs[k], 0, 0, 32'h0);
      checks++;
      if (ihit !== 1'b1 || imemload !== vals[k]) begin
        failures++;
        $display("FAIL conflict_data_%0d ihit=%b imemload=%h (want 1 %h)", k, ihit, imemload, vals[k]);
      end
      model_edge();
    end
    cyc(0, 32'h0, 0, 0, 32'h0);
    checks++;
    if (miss_cnt !== CW'(3)) begin
      failures++;
      $display("FAIL conflict_cnt miss=%0d (want 3)", miss_cnt);
    end
    model_edge();
  endtask

  task automatic test_stall();
    cyc(1, 32'h100, 0, 1, 32'h0);
    model_edge();
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 32'h100, 0, 1, $urandom);
      checks++;
      if (iREN !== 1'b1 || iaddr !== 32'h100 || ihit !== 1'b0) begin
        failures++;
        $display("FAIL stall_c%0d iREN=%b iaddr=%h ihit=%b (want 1 00000100 0)", i, iREN, iaddr, ihit);
      end
      model_edge();
    end
    cyc(1, 32'h100, 0, 0, 32'hDEAD_BEEF);
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h100 || ihit !== 1'b0) begin
      failures++;
      $display("FAIL stall_c7 iREN=%b iaddr=%h ihit=%b (want 1 00000100 0)", iREN, iaddr, ihit);
    end
    model_edge();
    cyc(1, 32'h100, 0, 0, 32'h0);
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'hDEAD_BEEF || iREN !== 1'b0) begin
      failures++;
      $display("FAIL stall_c8 ihit=%b imemload=%h iREN=%b (want 1 deadbeef 0)", ihit, imemload, iREN);
    end
    model_edge();
  endtask

  task automatic test_addr_change();
    cyc(1, 32'h200, 0, 0, 32'h0);
    model_edge();
    cyc(1, 32'h204, 0, 1, 32'h0);
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h200) begin
      failures++;
      $display("FAIL chg_hold iREN=%b iaddr=%h (want 1 00000200)", iREN, iaddr);
    end
    model_edge();
    cyc(1, 32'h204, 0, 0, 32'hA0A0_0200);
    checks++;
    if (iaddr !== 32'h200 || ihit !== 1'b0) begin
      failures++;
      $display("FAIL chg_fill iaddr=%h ihit=%b (want 00000200 0)", iaddr, ihit);
    end
    model_edge();
    cyc(1, 32'h204, 0, 0, 32'h0);
    checks++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      failures++;
      $display("FAIL chg_newmiss ihit=%b iREN=%b (want 0 0)", ihit, iREN);
    end
    model_edge();
    cyc(1, 32'h204, 0, 0, 32'hB0B0_0204);
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h204) begin
      failures++;
      $display("FAIL chg_fetch2 iREN=%b iaddr=%h (want 1 00000204)", iREN, iaddr);
    end
    model_edge();
    cyc(1, 32'h200, 0, 0, 32'h0);
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'hA0A0_0200) begin
      failures++;
      $display("FAIL chg_hit200 ihit=%b imemload=%h (want 1 a0a00200)", ihit, imemload);
    end
    model_edge();
    cyc(1, 32'h204, 0, 0, 32'h0);
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'hB0B0_0204) begin
      failures++;
      $display("FAIL chg_hit204 ihit=%b imemload=%h (want 1 b0b00204)", ihit, imemload);
    end
    model_edge();
  endtask

  task automatic test_halt();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h204, 1, 0, 32'h0);
      checks++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin
        failures++;
        $display("FAIL halt_hit_%0d ihit=%b iREN=%b (want 0 0)", i, ihit, iREN);
      end
      model_edge();
    end
    cyc(1, 32'h300, 1, 0, 32'h0);
    model_edge();
    cyc(1, 32'h300, 1, 0, 32'h0);
    checks++;
    if (iREN !== 1'b0) begin
      failures++;
      $display("FAIL halt_nomiss iREN=%b (want 0)", iREN);
    end
    model_edge();
    cyc(1, 32'h300, 0, 0, 32'h0);
    model_edge();
    cyc(1, 32'h300, 1, 1, 32'h0);
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h300) begin
      failures++;
      $display("FAIL halt_fetch iREN=%b iaddr=%h (want 1 00000300)", iREN, iaddr);
    end
    model_edge();
    cyc(1, 32'h300, 1, 0, 32'h3333_0300);
    model_edge();
    cyc(1, 32'h300, 1, 0, 32'h0);
    checks++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      failures++;
      $display("FAIL halt_after_fill ihit=%b iREN=%b (want 0 0)", ihit, iREN);
    end
    model_edge();
    cyc(1, 32'h300, 0, 0, 32'h0);
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'h3333_0300) begin
      failures++;
      $display("FAIL halt_filled ihit=%b imemload=%h (want 1 33330300)", ihit, imemload);
    end
    model_edge();
    cyc(1, 32'h204, 0, 0, 32'h0);
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'hB0B0_0204) begin
      failures++;
      $display("FAIL halt_retain ihit=%b imemload=%h (want 1 b0b00204)", ihit, imemload);
    end
    model_edge();
  endtask

  task automatic test_reset_mid_fetch();
    cyc(1, 32'h8, 0, 0, 32'h0000_0088);
    model_edge();
    cyc(1, 32'h8, 0, 0, 32'h0000_0088);
    model_edge();
    cyc(1, 32'h10C, 0, 0, 32'h0);
    model_edge();
    cyc(1, 32'h10C, 0, 1, 32'h0);
    checks++;
    if (iREN !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre iREN=%b (want 1)", iREN);
    end
    nRST = 1'b0; imemREN = 1'b0; iwait = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({iREN, iaddr, ihit, imemload, hit_cnt, miss_cnt} !== '0) begin
      failures++;
      $display("FAIL rst_mid iREN=%b iaddr=%h ihit=%b imemload=%h hit=%0d miss=%0d (want all 0)",
               iREN, iaddr, ihit, imemload, hit_cnt, miss_cnt);
    end
    @(negedge CLK);
    nRST = 1'b1;
    cyc(1, 32'h8, 0, 0, 32'h0);
    checks++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      failures++;
      $display("FAIL rst_remiss ihit=%b iREN=%b (want 0 0)", ihit, iREN);
    end
    model_edge();
    cyc(1, 32'h8, 0, 1, 32'h0);
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h8 || miss_cnt !== CW'(1)) begin
      failures++;
      $display("FAIL rst_refetch iREN=%b iaddr=%h miss=%0d (want 1 00000008 1)", iREN, iaddr, miss_cnt);
    end
    model_edge();
    cyc(1, 32'h8, 0, 0, 32'h0000_0888);
    model_edge();
  endtask

  task automatic test_saturation();
    do_reset();
    cyc(1, 32'h4, 0, 0, 32'h0000_0044);
    model_edge();
    cyc(1, 32'h4, 0, 0, 32'h0000_0044);
    model_edge();
    for (int i = 0; i < 70; i++) begin
      cyc(1, 32'h4, 0, 0, 32'h0);
      model_edge();
    end
    cyc(0, 32'h4, 0, 0, 32'h0);
    checks++;
    if (hit_cnt !== CW'(SAT)) begin
      failures++;
      $display("FAIL sat_hit hit=%0d (want %0d)", hit_cnt, SAT);
    end
    model_edge();
    for (int k = 0; k < 140; k++) begin
      cyc(1, (((k / 2) % 2) != 0) ? 32'h40 : 32'h0, 0, 0, 32'(k));
      model_edge();
    end
    cyc(0, 32'h0, 0, 0, 32'h0);
    checks++;
    if (miss_cnt !== CW'(SAT) || hit_cnt !== CW'(SAT)) begin
      failures++;
      $display("FAIL sat_miss miss=%0d hit=%0d (want %0d %0d)", miss_cnt, hit_cnt, SAT, SAT);
    end
    model_edge();
  endtask

  task automatic test_random();
    logic [31:0] a;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      a = 32'(($urandom_range(0, 2) << (IW + 2)) | ($urandom_range(0, NF - 1) << 2) |
              $urandom_range(0, 3));
      cyc($urandom_range(0, 9) < 8, a, $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) < 4, $urandom);
      checks++;
      if ({ihit, iREN, iaddr, imemload, hit_cnt, miss_cnt} !==
          {e_hit, e_ren, e_addr, e_load, CW'(m_hits), CW'(m_misses)}) begin
        failures++;
        $display("FAIL rand_%0d got ihit=%b iREN=%b iaddr=%h load=%h hit=%0d miss=%0d want %b %b %h %h %0d %0d",
                 n, ihit, iREN, iaddr, imemload, hit_cnt, miss_cnt,
                 e_hit, e_ren, e_addr, e_load, m_hits, m_misses);
      end
      model_edge();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_conflict();
    test_stall();
    test_addr_change();
    test_halt();
    test_reset_mid_fetch();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
